// File: rtl/imu_stim_pkg.sv
// Shared types and helpers for the IMU stimulus generator: mode encodings,
// LFSR constants, and the saturating / noise arithmetic used per channel.
package imu_stim_pkg;

  typedef enum logic [1:0] {
    MODE_CONST     = 2'd0,
    MODE_RAMP      = 2'd1,
    MODE_TRI       = 2'd2,
    MODE_TRI_NOISE = 2'd3
  } mode_e;

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] LFSR_SPREAD = 16'h1111;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [39:0] sat_to_width(input logic signed [39:0] v,
                                                      input int unsigned w);
    logic signed [39:0] hi;
    logic signed [39:0] lo;
    hi = (40'sd1 <<< (w - 32'd1)) - 40'sd1;
    lo = -hi - 40'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced with 1.
  function automatic logic [15:0] lfsr_seed(input logic [15:0] base, input int unsigned k);
    logic [15:0] s;
    s = base ^ (16'(k) * LFSR_SPREAD);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  // Low nb bits of the LFSR state, sign-extended.
  function automatic logic signed [39:0] lfsr_noise(input logic [15:0] s, input int unsigned nb);
    logic signed [39:0] v;
    v = {24'd0, s} & ((40'sd1 <<< nb) - 40'sd1);
    if (v[nb - 32'd1]) begin
      v = v - (40'sd1 <<< nb);
    end
    return v;
  endfunction

endpackage

// File: rtl/imu_stim_lfsr.sv
// 16-bit Galois LFSR noise source; advances once per asserted adv.
module imu_stim_lfsr
  import imu_stim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  output logic [15:0] state
);

  // LFSR state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (adv) begin
      state <= lfsr_next(state);
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/imu_stim_gen.sv
// Multi-channel IMU stimulus generator: prescaled CONST/RAMP/TRIANGLE
// waveforms with per-channel offset, optional LFSR noise and saturation.
module imu_stim_gen
  import imu_stim_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter int          NCH        = 3,
  parameter int          DIV        = 4,
  parameter int          STEP       = 1000,
  parameter int          AMP        = 4000,
  parameter int          CH_OFFSET  = 16384,
  parameter int          NOISE_BITS = 6,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  output logic [NCH*WIDTH-1:0]   samples,
  output logic                   sample_valid,
  output logic [CNT_W-1:0]       sample_cnt
);

  localparam int PW    = WIDTH + 1;
  localparam int EW    = WIDTH + 8;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic signed [PW-1:0]  STEP_P   = PW'(STEP);
  localparam logic signed [PW-1:0]  AMP_P    = PW'(AMP);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0]       presc_r;
  logic signed [PW-1:0]   phase_r;
  logic signed [PW-1:0]   phase_nxt_s;
  logic signed [PW-1:0]   tri_n_s;
  logic [WIDTH-1:0]       ramp_s;
  logic                   dir_down_r;
  logic                   dir_down_nxt_s;
  mode_e                  mode_q_r;
  logic                   tick_s;
  logic [NCH-1:0][15:0]   lfsr_s;
  logic [NCH*WIDTH-1:0]   samples_nxt_s;

  assign tick_s = en && (presc_r == PRE_LAST);

  // Next phase/direction; the resulting phase is what this tick's sample uses
  always_comb begin
    phase_nxt_s    = phase_r;
    dir_down_nxt_s = dir_down_r;
    tri_n_s        = '0;
    ramp_s         = '0;
    if (mode != mode_q_r) begin
      phase_nxt_s    = '0;
      dir_down_nxt_s = 1'b0;
    end else begin
      case (mode_q_r)
        MODE_CONST: begin
          phase_nxt_s    = '0;
          dir_down_nxt_s = 1'b0;
        end
        MODE_RAMP: begin
          ramp_s      = phase_r[WIDTH-1:0] + WIDTH'(STEP);
          phase_nxt_s = {ramp_s[WIDTH-1], ramp_s};
        end
        MODE_TRI, MODE_TRI_NOISE: begin
          if (!dir_down_r) begin
            tri_n_s = phase_r + STEP_P;
            if (tri_n_s >= AMP_P) begin
              phase_nxt_s    = AMP_P;
              dir_down_nxt_s = 1'b1;
            end else begin
              phase_nxt_s = tri_n_s;
            end
          end else begin
            tri_n_s = phase_r - STEP_P;
            if (tri_n_s <= -AMP_P) begin
              phase_nxt_s    = -AMP_P;
              dir_down_nxt_s = 1'b0;
            end else begin
              phase_nxt_s = tri_n_s;
            end
          end
        end
        default: begin
          phase_nxt_s    = '0;
          dir_down_nxt_s = 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic signed [EW-1:0] OFF_S = EW'(k * CH_OFFSET);
    logic signed [EW-1:0] noise_s;
    logic signed [EW-1:0] sum_s;

    imu_stim_lfsr #(
      .SEED(lfsr_seed(SEED, k))
    ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (tick_s),
      .state (lfsr_s[k])
    );

    // Channel value; noise uses the LFSR state before this tick's advance
    always_comb begin
      if (mode == MODE_TRI_NOISE) begin
        noise_s = EW'(lfsr_noise(lfsr_s[k], NOISE_BITS));
      end else begin
        noise_s = '0;
      end
      sum_s = EW'(phase_nxt_s) + OFF_S + noise_s;
    end

    assign samples_nxt_s[k*WIDTH +: WIDTH] = WIDTH'(sat_to_width(40'(sum_s), WIDTH));
  end

  // Prescaler, waveform state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r      <= '0;
      phase_r      <= '0;
      dir_down_r   <= 1'b0;
      mode_q_r     <= MODE_CONST;
      samples      <= '0;
      sample_valid <= 1'b0;
      sample_cnt   <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (tick_s) begin
        presc_r      <= '0;
        phase_r      <= phase_nxt_s;
        dir_down_r   <= dir_down_nxt_s;
        mode_q_r     <= mode_e'(mode);
        samples      <= samples_nxt_s;
        sample_valid <= 1'b1;
        sample_cnt   <= sample_cnt + CNT_W'(1);
      end else if (en) begin
        presc_r <= presc_r + PRE_W'(1);
      end else begin
        presc_r <= presc_r;
      end
    end
  end

endmodule

// File: tb/tb_imu_stim_gen.sv
// Scoreboard bench for imu_stim_gen: a waveform-level reference model queues
// expected samples per tick; a monitor compares whenever sample_valid rises.
module tb_imu_stim_gen;

  localparam int WIDTH = 16, NCH = 3, DIV = 4, STEP = 1000, AMP = 4000;
  localparam int CH_OFFSET = 16384, NOISE_BITS = 6, CNT_W = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic [1:0]           mode = 2'd0;
  logic [NCH*WIDTH-1:0] samples;
  logic                 sample_valid;
  logic [CNT_W-1:0]     sample_cnt;

  imu_stim_gen #(
    .WIDTH(WIDTH), .NCH(NCH), .DIV(DIV), .STEP(STEP), .AMP(AMP),
    .CH_OFFSET(CH_OFFSET), .NOISE_BITS(NOISE_BITS), .SEED(SEED), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .samples(samples), .sample_valid(sample_valid), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   cyc;
    logic [NCH*WIDTH-1:0] smp;
    logic [CNT_W-1:0]     cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic rst_seen = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, want);
    end
  endtask

  // ---------------- reference model (waveform level) ----------------
  int        m_en_cnt, m_t, m_mode_q, m_cnt;
  int        m_lfsr[NCH];

  function automatic int seed_of(int k);
    int s;
    s = (SEED ^ (k * 16'h1111)) & 16'hFFFF;
    return (s == 0) ? 1 : s;
  endfunction

  // Waveform value t ticks after a mode change (AMP is a multiple of STEP).
  function automatic longint wave(int m, int t);
    longint v;
    int qn, p;
    case (m)
      1: begin
        v = (longint'(t) * STEP) % 65536;
        if (v >= 32768) v -= 65536;
      end
      2, 3: begin
        qn = AMP / STEP;
        p  = t % (4 * qn);
        if (p <= qn)          v = p;
        else if (p <= 3 * qn) v = 2 * qn - p;
        else                  v = p - 4 * qn;
        v = v * STEP;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic model_cycle(input bit r, input bit e, input int m);
    exp_t   x;
    longint v, nz;
    if (!r) begin
      m_en_cnt = 0; m_t = 0; m_mode_q = 0; m_cnt = 0;
      for (int k = 0; k < NCH; k++) m_lfsr[k] = seed_of(k);
      return;
    end
    if (!e) return;
    m_en_cnt++;
    if (m_en_cnt % DIV != 0) return;
    if (m != m_mode_q) begin
      m_mode_q = m;
      m_t = 0;
    end else begin
      m_t++;
    end
    x.smp = '0;
    for (int k = 0; k < NCH; k++) begin
      nz = m_lfsr[k] % 64;
      if (nz >= 32) nz -= 64;
      v = wave(m_mode_q, m_t) + longint'(k) * CH_OFFSET + ((m == 3) ? nz : 0);
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      x.smp[k*WIDTH +: WIDTH] = 16'(v);
      if (m_lfsr[k] % 2 == 1) m_lfsr[k] = (m_lfsr[k] / 2) ^ 16'hB400;
      else                    m_lfsr[k] = m_lfsr[k] / 2;
    end
    m_cnt = (m_cnt + 1) % 65536;
    x.cnt = 16'(m_cnt);
    x.cyc = cyc + 1;
    q.push_back(x);
  endtask

  task automatic drive(input bit r, input bit e, input int m);
    rst_n = r;
    en    = e;
    mode  = 2'(m);
    model_cycle(r, e, m);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic [NCH*WIDTH-1:0] last_smp = '0;
  logic [CNT_W-1:0]     last_cnt = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_seen) begin
        check("reset_samples", 64'(samples), 64'd0);
        check("reset_valid", 64'(sample_valid), 64'd0);
        check("reset_cnt", 64'(sample_cnt), 64'd0);
        q.delete();
        last_smp = '0;
        last_cnt = '0;
      end else if (sample_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("spurious_valid", 64'(sample_valid), 64'd0);
        end else begin
          e = q.pop_front();
          check("valid_cycle", 64'(cyc), 64'(e.cyc));
          check("samples", 64'(samples), 64'(e.smp));
          check("sample_cnt", 64'(sample_cnt), 64'(e.cnt));
        end
        last_smp = samples;
        last_cnt = sample_cnt;
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          check("missing_valid", 64'(sample_valid), 64'd1);
          void'(q.pop_front());
        end
        check("hold_samples", 64'(samples), 64'(last_smp));
        check("hold_cnt", 64'(sample_cnt), 64'(last_cnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #1;
    for (int i = 0; i < 5; i++) drive(0, 1, 0);
    for (int i = 0; i < 24; i++) drive(1, 1, 0);          // CONST
    for (int i = 0; i < 70; i++) drive(1, 1, 2);          // TRIANGLE
    for (int i = 0; i < 10; i++) drive(1, 0, 2);          // frozen
    for (int i = 0; i < 30; i++) drive(1, 1, 2);
    for (int i = 0; i < 140; i++) drive(1, 1, 1);         // RAMP through wrap
    for (int i = 0; i < 40; i++) drive(1, 1, 2);          // RAMP -> TRI
    for (int i = 0; i < 120; i++) drive(1, 1, 3);         // TRI_NOISE
    for (int i = 0; i < 3; i++) drive(0, 1, 3);           // mid-run reset
    for (int i = 0; i < 80; i++) drive(1, 1, 3);          // repeat from reset
    for (int i = 0; i < 600; i++) begin : rnd
      int m;
      m = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : int'(mode);
      drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), m);
    end
    for (int i = 0; i < 4; i++) drive(1, 0, int'(mode));
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
